// File: rtl/adc366x_pkg.sv
// Shared constants and FSM state encoding for the ADC366x receiver delay calibration.
package adc366x_pkg;
   localparam int TAPS   = 32;
   localparam int TAPW   = 5;
   localparam int LD_BIT = 25;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_MEAS,
      S_NEXT,
      S_APPLY,
      S_APPLY_LD,
      S_DONE
   } state_t;
endpackage

// File: rtl/adc366x_eye_track.sv
// Per-lane passing-window tracker: finds the longest run of passing taps
// (earliest wins a tie) and reports its centre tap.
module adc366x_eye_track
   import adc366x_pkg::*;
(
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            clr,
   input  logic            upd,
   input  logic            pass,
   input  logic [TAPW-1:0] tap,
   output logic [TAPW-1:0] res,
   output logic            fail
);
   localparam logic [TAPW-1:0] TAP_MAX = TAPW'(TAPS - 1);

   logic            open_q;
   logic [TAPW-1:0] run_start, best_start, cur_start, half;
   logic [TAPW:0]   best_len, run_len;
   logic            close;

   // A run closes on the first failing tap, or at the last tap if still passing.
   always_comb begin
      cur_start = open_q ? run_start : tap;
      close     = 1'b0;
      run_len   = '0;
      if (pass && tap == TAP_MAX) begin
         close   = 1'b1;
         run_len = (TAPW+1)'(TAPS) - {1'b0, cur_start};
      end else if (!pass && open_q) begin
         close   = 1'b1;
         run_len = {1'b0, tap} - {1'b0, run_start};
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         open_q     <= 1'b0;
         run_start  <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else if (clr) begin
         open_q     <= 1'b0;
         run_start  <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else if (upd) begin
         open_q <= pass && (tap != TAP_MAX);
         if (pass && !open_q)
            run_start <= tap;
         if (close && run_len > best_len) begin
            best_start <= cur_start;
            best_len   <= run_len;
         end
      end
   end

   always_comb begin
      half = TAPW'((best_len - 1'b1) >> 1);
      fail = (best_len == '0);
      res  = fail ? '0 : best_start + half;
   end
endmodule

// File: rtl/adc366x_dly_cal.sv
// Sweeps all receiver delay taps, measures test-pattern errors per lane and
// loads the centre of each lane's widest passing window.
module adc366x_dly_cal
   import adc366x_pkg::*;
#(
   parameter int LW     = 2,
   parameter int SW     = LW*2+1,
   parameter int NSAMP  = 256,
   parameter int SETTLE = 64,
   parameter int LDHOLD = 16,
   parameter int TMO    = 4096
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          start_i,
   input  logic          mon_vld_i,
   input  logic [SW-1:0] mon_err_i,
   output logic [LD_BIT:0] cfg_dly_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [SW-1:0] fail_o
);
   localparam int              NLANE   = LD_BIT / TAPW;
   localparam logic [31:0]     LD_END  = 32'(LDHOLD - 1);
   localparam logic [31:0]     ST_END  = 32'(SETTLE - 1);
   localparam logic [31:0]     MS_END  = 32'(NSAMP - 1);
   localparam logic [31:0]     TO_END  = 32'(TMO - 1);
   localparam logic [TAPW-1:0] TAP_MAX = TAPW'(TAPS - 1);

   state_t            state_q, state_d;
   logic [31:0]       cnt_q, tmo_q;
   logic [TAPW-1:0]   tap_q, tap_nx;
   logic [SW-1:0]     err_q, fail_q, lane_fail;
   logic              to_q, clr, upd, strobe, timeout;
   logic [LD_BIT-1:0] cfg_tap_q, res_bus;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      upd     = 1'b0;
      strobe  = 1'b0;
      timeout = 1'b0;
      busy_o  = 1'b1;
      done_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               clr     = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            strobe = 1'b1;
            if (cnt_q == LD_END) state_d = S_SETTLE;
         end
         S_SETTLE: if (cnt_q == ST_END) state_d = S_MEAS;
         S_MEAS: begin
            if (mon_vld_i && cnt_q == MS_END) begin
               state_d = S_NEXT;
            end else if (!mon_vld_i && tmo_q == TO_END) begin
               timeout = 1'b1;
               state_d = S_APPLY;
            end
         end
         S_NEXT: begin
            upd     = 1'b1;
            state_d = (tap_q == TAP_MAX) ? S_APPLY : S_LOAD;
         end
         S_APPLY: state_d = S_APPLY_LD;
         S_APPLY_LD: begin
            strobe = 1'b1;
            if (cnt_q == LD_END) state_d = S_DONE;
         end
         S_DONE: begin
            busy_o  = 1'b0;
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tap_nx = tap_q + 1'b1;

   // Phase counter restarts on every state change; in MEAS it counts valid samples only.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q     <= '0;
         tmo_q     <= '0;
         tap_q     <= '0;
         err_q     <= '0;
         fail_q    <= '0;
         to_q      <= 1'b0;
         cfg_tap_q <= '0;
      end else begin
         if (state_d != state_q) begin
            cnt_q <= '0;
            tmo_q <= '0;
         end else if (state_q == S_MEAS) begin
            if (mon_vld_i) begin
               cnt_q <= cnt_q + 1'b1;
               tmo_q <= '0;
            end else begin
               tmo_q <= tmo_q + 1'b1;
            end
         end else if (state_q != S_IDLE) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (state_q == S_SETTLE)
            err_q <= '0;
         else if (state_q == S_MEAS && mon_vld_i)
            err_q <= err_q | mon_err_i;

         if (clr) begin
            tap_q     <= '0;
            cfg_tap_q <= '0;
            fail_q    <= '0;
            to_q      <= 1'b0;
         end
         if (upd && tap_q != TAP_MAX) begin
            tap_q     <= tap_nx;
            cfg_tap_q <= {NLANE{tap_nx}};
         end
         if (timeout) begin
            fail_q <= '1;
            to_q   <= 1'b1;
         end
         if (state_q == S_APPLY) begin
            cfg_tap_q <= to_q ? '0 : res_bus;
            fail_q    <= to_q ? '1 : lane_fail;
         end
      end
   end

   for (genvar i = 0; i < SW; i++) begin : g_lane
      adc366x_eye_track u_trk (
         .clk_i  (clk_i),
         .rstn_i (rstn_i),
         .clr    (clr),
         .upd    (upd),
         .pass   (~err_q[i]),
         .tap    (tap_q),
         .res    (res_bus[TAPW*i +: TAPW]),
         .fail   (lane_fail[i])
      );
   end
   if (SW < NLANE) begin : g_pad
      assign res_bus[LD_BIT-1:TAPW*SW] = '0;
   end

   assign cfg_dly_o = {strobe, cfg_tap_q};
   assign fail_o    = fail_q;
endmodule

// File: doc/adc366x_dly_cal.md
ADC366X_DLY_CAL -- requirements
Module: adc366x_dly_cal

Interface
REQ-001 The block SHALL have parameter LW, default 2, meaning ADC lanes per channel.
REQ-002 The block SHALL have parameter SW, default LW*2+1, meaning the number of serial lanes (data plus frame).
REQ-003 The block SHALL have parameter NSAMP, default 256, meaning monitor samples checked per tap.
REQ-004 The block SHALL have parameter SETTLE, default 64, meaning wait cycles after a tap load before measuring.
REQ-005 The block SHALL have parameter LDHOLD, default 16, meaning the number of cycles the load strobe is held high.
REQ-006 The block SHALL have parameter TMO, default 4096, meaning the maximum number of cycles between monitor samples.
REQ-007 The block SHALL have port clk_i, input, 1 bit: the only clock, the configuration-domain clock.
REQ-008 The block SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port start_i, input, 1 bit: a one-cycle request to calibrate.
REQ-010 The block SHALL have port mon_vld_i, input, 1 bit: a monitor sample strobe, already synchronised to clk_i.
REQ-011 The block SHALL have port mon_err_i, input, SW bits: a per-lane test-pattern mismatch flag, qualified by mon_vld_i.
REQ-012 The block SHALL have port cfg_dly_o, output, 26 bits: the receiver delay control; bits [5*i+:5] are the tap of lane i and bit 25 is the load strobe.
REQ-013 The block SHALL have port busy_o, output, 1 bit: high while a calibration is in progress.
REQ-014 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse when a calibration finishes.
REQ-015 The block SHALL have port fail_o, output, SW bits: per-lane "no passing tap or timeout" flags, valid from done_o until the next start.

Function
REQ-016 The FSM states SHALL be IDLE, LOAD, SETTLE, MEAS, NEXT, APPLY, APPLY_LD, DONE.
- IDLE: start_i=1 -> LOAD with tap=0; clear all trackers and fail_o; busy_o=1 from the next cycle.
- LOAD: all lane taps equal tap; bit 25 = 1 for LDHOLD cycles -> SETTLE.
- SETTLE: bit 25 = 0; count SETTLE cycles -> MEAS.
- MEAS: count NSAMP cycles with mon_vld_i=1; OR mon_err_i into a per-lane error accumulator on those cycles -> NEXT when the count reaches NSAMP.
- NEXT: update the trackers with pass = !err; tap<31 -> tap+1, LOAD; tap==31 -> APPLY.
REQ-017 In MEAS, when TMO cycles elapse without mon_vld_i, the block SHALL set fail_o to all ones, skip the remaining taps and go to APPLY with all taps = 0.
REQ-018 Per-lane tracker behaviour:
- Runs: a run opens on pass at the current tap (records start); it closes on a fail or after tap 31 evaluated as pass.
- Best run: kept only if its length is strictly greater than the stored best; ties keep the earliest run.
REQ-019 Per-lane result: tap = best_start + ((best_len-1)>>1); 5-bit unsigned arithmetic; no overflow is possible since best_start+best_len<=32.
REQ-020 A lane with best_len==0 SHALL get fail_o[i]=1 and tap 0.
REQ-021 APPLY SHALL drive the per-lane result taps and enter APPLY_LD, which asserts bit 25 for LDHOLD cycles, then DONE.
REQ-022 DONE SHALL assert done_o for one cycle, drop busy_o in the same cycle, and return to IDLE.
REQ-023 In IDLE, cfg_dly_o taps SHALL hold the last applied results and bit 25 = 0.
REQ-024 start_i while busy_o=1 SHALL be ignored.
REQ-025 mon_vld_i outside MEAS SHALL be ignored.
REQ-026 A start_i coincident with DONE SHALL be ignored.
REQ-027 The number of cycles from start_i to done_o with no timeout SHALL be deterministic given mon_vld_i timing: 32*(LDHOLD+SETTLE+measure+1)+LDHOLD+3 approx; the exact count is checked against the model.

Reset
REQ-028 While rstn_i=0 the block SHALL asynchronously force: state IDLE, cfg_dly_o=0, busy_o=0, done_o=0, fail_o=0, all counters and trackers 0.
REQ-029 Reset mid-calibration SHALL abandon the sweep with no done_o; the taps become 0 and calibration restarts only on a new start_i.
REQ-030 Deassertion of rstn_i SHALL be synchronised to clk_i by the integrator; the block itself does not resynchronise.

Structure
REQ-031 Package adc366x_pkg SHALL hold the FSM state enum, the TAPS=32 and TAPW=5 constants, and the cfg_dly bit-25 load-strobe index.
REQ-032 The sub-module adc366x_eye_track SHALL be instantiated once per lane (generate), with inputs clk_i, rstn_i, clr, upd, pass and tap, and output result tap and fail.
REQ-033 All sequencing SHALL live in adc366x_dly_cal; no clock-domain crossings inside.

Verification
REQ-034 Scenario (all pass): mon_err_i=0 always -> every lane tap 15, fail_o=0, one done_o pulse.
REQ-035 Scenario (window): lane 2 passes only on taps 10..20 -> lane 2 tap 15; the others tap 15.
REQ-036 Scenario (tie/edge): lane 0 passes on taps 0..3 and 28..31 -> tap 1 (earliest run); lane 1 passes on 31 only -> tap 31.
REQ-037 Scenario (dead lane): lane 4 err=1 on all taps -> fail_o=5'b10000, tap 0; the others unaffected.
REQ-038 Scenario (timeout): mon_vld_i stops at tap 7 -> after TMO cycles fail_o=5'b11111, taps 0, done_o pulse.
REQ-039 Scenario (reset/ignore): start_i repeated mid-sweep -> no effect; rstn_i pulsed at tap 12 -> outputs 0, no done_o; the strobe is high exactly LDHOLD cycles per load.
